// File: rtl/ins_fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit and its cache.
package ins_fetch_unit_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          INSTR_W      = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MISS  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ins_fetch_unit_icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache: combinational lookup,
// single write port, and a flush that invalidates every line at once.
module icache_dm
    import ins_fetch_unit_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IDX_W-1:0]   i_rd_idx,
    input  logic [TAG_W-1:0]   i_rd_tag,
    output logic               o_hit,
    output logic [INSTR_W-1:0] o_rd_data,
    input  logic               i_wr_en,
    input  logic [IDX_W-1:0]   i_wr_idx,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [INSTR_W-1:0] i_wr_data,
    input  logic               i_flush
);

    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [INSTR_W-1:0] r_data [LINES];

    // Flush wins over a coincident fill, so the filled line stays invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en && !i_flush) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_hit     = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_data = r_data[i_rd_idx];

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: PC, miss FSM (RUN/MISS/DRAIN) and one-entry output buffer.
// Optional hit/miss counters are built when IF_PERF_CNT_EN is defined.
module ins_fetch_unit
    import ins_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                ICACHE_LINES = 64,
    parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(RESET_PC_DEF)
) (
`ifdef IF_PERF_CNT_EN
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt,
`endif
    input  logic                clk,
    input  logic                reset,
    input  logic                rdy,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [INSTR_W-1:0]  mem_data,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                icache_flush,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                issue_ready
);

    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    fetch_state_e        r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
    logic                r_mem_req, w_mem_req_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic                r_instr_valid, w_vld_nxt;
    logic [INSTR_W-1:0]  r_instr, w_instr_nxt;
    logic [ADDR_W-1:0]   r_instr_pc, w_instr_pc_nxt;

    logic                w_hit;
    logic [INSTR_W-1:0]  w_line_data;
    logic                w_buf_free;
    logic                w_fill;
    logic                w_hit_take;
    logic                w_miss_start;
    logic [ADDR_W-1:0]   w_redirect_pc;
    logic                w_unused_lsb;

    assign w_redirect_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_unused_lsb  = ^redirect_pc[1:0];
    assign w_buf_free    = !r_instr_valid || issue_ready;

    icache_dm #(
        .LINES (ICACHE_LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_icache (
        .clk       (clk),
        .reset     (reset),
        .i_rd_idx  (r_pc[IDX_W+1:2]),
        .i_rd_tag  (r_pc[ADDR_W-1:IDX_W+2]),
        .o_hit     (w_hit),
        .o_rd_data (w_line_data),
        .i_wr_en   (rdy && !reset && w_fill),
        .i_wr_idx  (r_mem_addr[IDX_W+1:2]),
        .i_wr_tag  (r_mem_addr[ADDR_W-1:IDX_W+2]),
        .i_wr_data (mem_data),
        .i_flush   (rdy && icache_flush)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        w_vld_nxt      = r_instr_valid;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_fill         = 1'b0;
        w_hit_take     = 1'b0;
        w_miss_start   = 1'b0;

        if (r_instr_valid && issue_ready) begin
            w_vld_nxt = 1'b0;
        end

        case (r_state)
            ST_RUN: begin
                // A redirect discards whatever the lookup found this cycle.
                if (!redirect_valid) begin
                    if (w_hit) begin
                        if (w_buf_free) begin
                            w_vld_nxt      = 1'b1;
                            w_instr_nxt    = w_line_data;
                            w_instr_pc_nxt = r_pc;
                            w_pc_nxt       = r_pc + ADDR_W'(4);
                            w_hit_take     = 1'b1;
                        end
                    end else begin
                        w_mem_req_nxt  = 1'b1;
                        w_mem_addr_nxt = {r_pc[ADDR_W-1:2], 2'b00};
                        w_state_nxt    = ST_MISS;
                        w_miss_start   = 1'b1;
                    end
                end
            end
            ST_MISS, ST_DRAIN: begin
                // The returning word always belongs to r_mem_addr, so filling is safe
                // even after a redirect has moved the PC elsewhere.
                if (mem_ack) begin
                    w_fill        = 1'b1;
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = ST_RUN;
                end else if (redirect_valid) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (redirect_valid) begin
            w_pc_nxt  = w_redirect_pc;
            w_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_pc          <= {RESET_PC[ADDR_W-1:2], 2'b00};
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
        end else if (rdy) begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_instr_valid <= w_vld_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (rdy) begin
            if (w_hit_take) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss_start) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    logic w_unused_perf;
    assign w_unused_perf = w_hit_take ^ w_miss_start;
`endif

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Directed bench for ins_fetch_unit: cold miss, hit stream with stall, conflict,
// redirect during miss, flush cases and rdy freeze.
module tb_ins_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        rdy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        icache_flush;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        issue_ready;
`ifdef IF_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit watch40 = 1'b0;
    bit saw40   = 1'b0;

    always #5 clk = ~clk;

    ins_fetch_unit dut (
`ifdef IF_PERF_CNT_EN
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt),
`endif
        .clk            (clk),
        .reset          (reset),
        .rdy            (rdy),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .icache_flush   (icache_flush),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .issue_ready    (issue_ready)
    );

    always @(negedge clk) begin
        if (watch40 && instr_valid && instr_pc == 32'h40) saw40 <= 1'b1;
    end

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0013 : (32'hC0DE_0000 | {16'h0, a[15:0]});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // While a miss is outstanding: ack it and redirect in the same cycle.
    task automatic jump(input logic [31:0] to_pc, input logic [31:0] miss_addr);
        chk("jump_req", 32'(mem_req), 32'd1);
        chk("jump_addr", mem_addr, miss_addr);
        redirect_valid = 1'b1;
        redirect_pc    = to_pc;
        mem_ack        = 1'b1;
        mem_data       = mdata(miss_addr);
        tick();
        redirect_valid = 1'b0;
        mem_ack        = 1'b0;
    endtask

    task automatic ack_now(input logic [31:0] d);
        mem_ack  = 1'b1;
        mem_data = d;
        tick();
        mem_ack  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rdy = 1'b1; mem_ack = 1'b0; mem_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; icache_flush = 1'b0; issue_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);

        // cold miss with 3-cycle ack delay
        reset = 1'b0;
        tick();
        chk("cold_req0", 32'(mem_req), 32'd1);
        chk("cold_addr0", mem_addr, 32'h0);
        tick();
        chk("cold_req1", 32'(mem_req), 32'd1);
        tick();
        chk("cold_req2", 32'(mem_req), 32'd1);
        chk("cold_addr2", mem_addr, 32'h0);
        ack_now(32'h13);
        chk("cold_req_drop", 32'(mem_req), 32'd0);
        chk("cold_valid_early", 32'(instr_valid), 32'd0);
        tick();
        chk("cold_valid", 32'(instr_valid), 32'd1);
        chk("cold_instr", instr, 32'h13);
        chk("cold_pc", instr_pc, 32'h0);

        // next pc 0x4 misses; refetch 0 hits without a request
        tick();
        jump(32'h0, 32'h4);
        tick();
        chk("refetch_noreq", 32'(mem_req), 32'd0);
        chk("refetch_valid", 32'(instr_valid), 32'd1);
        chk("refetch_pc", instr_pc, 32'h0);
        chk("refetch_instr", instr, 32'h13);
        tick();
        chk("park_noreq", 32'(mem_req), 32'd0);
        chk("park_pc", instr_pc, 32'h0);

        // preload 0x8 and 0xC, then stream 0x4..0xC with backpressure
        redirect_valid = 1'b1; redirect_pc = 32'h8;
        tick();
        redirect_valid = 1'b0;
        tick();
        jump(32'hC, 32'h8);
        tick();
        jump(32'h4, 32'hC);
        tick();
        chk("stream_valid", 32'(instr_valid), 32'd1);
        chk("stream_pc4", instr_pc, 32'h4);
        chk("stream_instr4", instr, mdata(32'h4));
        tick();
        chk("stall1_pc", instr_pc, 32'h4);
        tick();
        chk("stall2_pc", instr_pc, 32'h4);
        chk("stall2_noreq", 32'(mem_req), 32'd0);
        issue_ready = 1'b1;
        tick();
        chk("stream_pc8", instr_pc, 32'h8);
        chk("stream_valid8", 32'(instr_valid), 32'd1);
        tick();
        chk("stream_pcC", instr_pc, 32'hC);
        chk("stream_instrC", instr, mdata(32'hC));
        issue_ready = 1'b0;
        tick();

        // conflict: 0x100 shares index 0 with 0x000
        jump(32'h100, 32'h10);
        tick();
        chk("conf_req", 32'(mem_req), 32'd1);
        chk("conf_addr", mem_addr, 32'h100);
        jump(32'h0, 32'h100);
        tick();
        chk("conf_remiss_req", 32'(mem_req), 32'd1);
        chk("conf_remiss_addr", mem_addr, 32'h0);

        // redirect to 0x80 two cycles into the miss of 0x40
        jump(32'h40, 32'h0);
        tick();
        chk("drn_req", 32'(mem_req), 32'd1);
        chk("drn_addr", mem_addr, 32'h40);
        watch40 = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        chk("drn_state", 32'(dut.r_state), 32'd2);
        chk("drn_req_hold", 32'(mem_req), 32'd1);
        chk("drn_addr_hold", mem_addr, 32'h40);
        tick();
        chk("drn_state2", 32'(dut.r_state), 32'd2);
        chk("drn_req_hold2", 32'(mem_req), 32'd1);
        ack_now(mdata(32'h40));
        chk("drn_req_drop", 32'(mem_req), 32'd0);
        chk("drn_run", 32'(dut.r_state), 32'd0);
        tick();
        chk("drn_new_req", 32'(mem_req), 32'd1);
        chk("drn_new_addr", mem_addr, 32'h80);
        ack_now(mdata(32'h80));
        tick();
        chk("drn_out_valid", 32'(instr_valid), 32'd1);
        chk("drn_out_pc", instr_pc, 32'h80);
        chk("drn_out_instr", instr, mdata(32'h80));
        tick();
        chk("drn_no40", 32'(saw40), 32'd0);
        watch40 = 1'b0;
        jump(32'h40, 32'h84);
        tick();
        chk("fill40_noreq", 32'(mem_req), 32'd0);
        chk("fill40_pc", instr_pc, 32'h40);
        chk("fill40_instr", instr, mdata(32'h40));
        tick();

        // flush: same-cycle hit still delivered, later refetch misses
        jump(32'h0, 32'h44);
        icache_flush = 1'b1;
        tick();
        icache_flush = 1'b0;
        chk("fl_hit_valid", 32'(instr_valid), 32'd1);
        chk("fl_hit_pc", instr_pc, 32'h0);
        chk("fl_hit_instr", instr, 32'h13);
        tick();
        jump(32'h0, 32'h4);
        tick();
        chk("fl_refetch_req", 32'(mem_req), 32'd1);
        chk("fl_refetch_addr", mem_addr, 32'h0);
        icache_flush = 1'b1;
        ack_now(32'h13);
        icache_flush = 1'b0;
        chk("fl_ack_reqdrop", 32'(mem_req), 32'd0);
        tick();
        chk("fl_ack_invalid_req", 32'(mem_req), 32'd1);
        chk("fl_ack_invalid_addr", mem_addr, 32'h0);

        // rdy low for 5 cycles mid-miss with an ack during the freeze
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ack  = (i == 2);
            mem_data = 32'h13;
            tick();
            chk("frz_req", 32'(mem_req), 32'd1);
            chk("frz_addr", mem_addr, 32'h0);
        end
        mem_ack = 1'b0;
        rdy = 1'b1;
        tick();
        chk("frz_after_req", 32'(mem_req), 32'd1);
        chk("frz_after_state", 32'(dut.r_state), 32'd1);
        ack_now(32'h13);
        chk("frz_fill_reqdrop", 32'(mem_req), 32'd0);
        tick();
        chk("frz_out_valid", 32'(instr_valid), 32'd1);
        chk("frz_out_instr", instr, 32'h13);
        chk("frz_out_pc", instr_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ins_fetch_unit.md
Name: ins_fetch_unit

Overview:
Parametrised instruction fetch unit with a direct-mapped, one-word-per-line instruction cache. It owns the PC, serves hits in one cycle, and fills misses through a req/ack handshake to the memory controller. It delivers instructions with their PC to the issue stage over a valid/ready handshake, and accepts PC redirects and whole-cache invalidation. It sits between the memory controller and the issuer.

Parameters:
ADDR_W, 32, PC and memory address width.
ICACHE_LINES, 64, number of cache lines; power of 2, at least 2.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
rdy  in  1  global enable; low freezes all state and holds all outputs.
mem_req  out  1  fetch request to the memory controller.
mem_addr  out  ADDR_W  word-aligned fetch address.
mem_ack  in  1  one-cycle pulse: mem_data is valid for the current request.
mem_data  in  32  returned instruction word.
redirect_valid  in  1  branch/exception redirect.
redirect_pc  in  ADDR_W  new PC; bits [1:0] are ignored.
icache_flush  in  1  invalidate all lines (fence.i).
instr_valid  out  1  output buffer holds an instruction.
instr  out  32  instruction word.
instr_pc  out  ADDR_W  PC of instr.
issue_ready  in  1  issuer accepts instr this cycle.

Behaviour:
- Address split: IDX_W = log2(ICACHE_LINES). index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. Storage per line: valid, tag, data.
- Reset (reset high, rdy ignored): pc = RESET_PC; state = RUN; all valid bits = 0; mem_req = 0; mem_addr = 0; instr_valid = 0; instr = 0; instr_pc = 0.
- rdy low: no state change. mem_req and mem_addr hold their values. mem_ack, redirect_valid, icache_flush and issue_ready are ignored that cycle.
- Output buffer: one entry, registered.
  - Free when instr_valid == 0 or issue_ready == 1.
  - A transfer is instr_valid && issue_ready.
  - The buffer is only overwritten when it is free.
- FSM states:
  - RUN:
    - Lookup of pc is combinational.
    - Hit and buffer free: next cycle instr = line data, instr_pc = pc, instr_valid = 1, pc += 4 (wraps modulo 2^ADDR_W).
    - Hit and buffer not free: stall, pc unchanged.
    - Miss: mem_req <= 1, mem_addr <= {pc[ADDR_W-1:2], 2'b00}, go to MISS.
  - MISS:
    - mem_req stays high and mem_addr stays stable until mem_ack.
    - On mem_ack: write line (valid=1, tag, mem_data), mem_req <= 0, go to RUN. The next cycle hits.
    - Miss penalty = memory latency + 2 cycles.
  - DRAIN:
    - Entered when a redirect arrives in MISS.
    - Keeps the request alive. On mem_ack: fill the line (the data belongs to the old address, so the fill is legal), mem_req <= 0, go to RUN.
- Redirect (highest priority among non-reset events):
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; instr_valid <= 0 the next cycle.
  - Any lookup result in the same cycle is discarded.
  - RUN stays RUN. MISS goes to DRAIN. DRAIN stays DRAIN.
  - Redirect and mem_ack in the same cycle while in MISS: fill the line, go to RUN with the new pc.
- icache_flush: all valid bits cleared next cycle.
  - A hit in the same cycle is still delivered.
  - flush and mem_ack in the same cycle: the fill is dropped (the line stays invalid).
- mem_ack outside MISS/DRAIN is ignored.

Optional Feature:
IF_PERF_CNT_EN: when defined, adds output ports hit_cnt[31:0] and miss_cnt[31:0].
- hit_cnt increments once per hit delivered into the buffer.
- miss_cnt increments once per RUN→MISS transition.
- Both counters wrap, reset to 0, and freeze while rdy is low.
When not defined, neither the ports nor the logic exist, and behaviour is otherwise identical.

Decomposition:
- Shared constants package: ADDR_W default, instruction width 32, RESET_PC default, FSM state encoding (RUN=0, MISS=1, DRAIN=2).
- One sub-module, icache_dm: valid/tag/data arrays, combinational lookup (hit, data), single write port, flush-all.
- The FSM, PC and output buffer stay in ins_fetch_unit.

Test Plan:
- Cold miss: reset, RESET_PC=0, memory returns 0x00000013 with a 3-cycle ack delay.
  - Required: mem_req=1 with mem_addr=0 until ack.
  - Required: instr_valid=1, instr=0x13, instr_pc=0 two cycles after ack.
  - Required: a re-fetch of 0 later hits with no mem_req.
- Hit stream with backpressure: lines 0x0–0xC preloaded; issue_ready low for 2 cycles.
  - Required: instr_pc holds at 0x4 while stalled, then 0x8 and 0xC on consecutive cycles.
- Conflict: ICACHE_LINES=64, fetch 0x000 then 0x100 (same index).
  - Required: a second fill occurs, and a later fetch of 0x000 misses again.
- Redirect during miss: redirect_pc=0x80 two cycles into the miss of 0x40.
  - Required: state goes to DRAIN and mem_req stays high until ack.
  - Required: line 0x40 is filled, then 0x80 is fetched, and the 0x40 instruction is never output.
- Flush: after filling 0x0, pulse icache_flush.
  - Required: the next fetch of 0x0 asserts mem_req.
  - Required: flush coincident with mem_ack leaves the line invalid.
- rdy low mid-miss for 5 cycles with mem_ack pulsed during the freeze.
  - Required: the ack is ignored, mem_req/mem_addr stay stable, and the fill completes on an ack after rdy returns.
